// File: rtl/spi_reg_pkg.sv
// Definitions shared by the SPI register-write controller and the peripheral
// that consumes its frames.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam logic WRITE_FLAG = 1'b1;

  // Counter widths are wide enough for the full legal parameter ranges.
  localparam int PHASE_W   = 8;
  localparam int GAP_W     = 8;
  localparam int BIT_CNT_W = 4;

  // Register map of the peripheral.
  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  // ST_SETUP: nCS low, SCLK low, first bit presented.
  // ST_HIGH / ST_LOW: SCLK half periods.
  // ST_HOLD: final low half period after the 16th bit, nCS still low.
  // ST_GAP: nCS high recovery time before the next frame.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

endpackage

// File: rtl/spi_reg_writer_if.sv
// Request handshake and SPI pins of the register writer, plus the FSM state
// for observation.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_addr/req_data must be valid in that cycle and
// are not looked at again. req_ready is only high while the controller is
// idle.
interface spi_reg_writer_if;
  import spi_reg_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       SCLK;
  logic       COPI;
  logic       nCS;
  logic       busy;
  logic       done;
  state_t     state;

  // Requester side.
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, SCLK, COPI, nCS, busy, done, state
  );

  // Controller side.
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, SCLK, COPI, nCS, busy, done, state
  );

endinterface

// File: rtl/spi_phase_tick.sv
// SCLK phase timer: counts 0..CLK_DIV-1 and wraps, flagging the last cycle of
// each phase. Clearing on acceptance aligns phase boundaries to the frame.
module spi_phase_tick
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(CLK_DIV - 1);

  logic [PHASE_W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // Phase counter with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_reg_writer.sv
// Mode-0 SPI register writer: serialises {WRITE_FLAG, addr, data} MSB first
// with a CLK_DIV-cycle half period, then keeps nCS high for GAP_CYCLES cycles.
module spi_reg_writer
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  spi_reg_writer_if.slave bus
);

  state_t                 state_q;
  state_t                 state_d;
  logic [FRAME_BITS-1:0]  shift_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [GAP_W-1:0]       gap_cnt_q;

  logic sclk_q, ncs_q, busy_q, done_q, ready_q;
  logic sclk_d, ncs_d, busy_d, done_d, ready_d;
  logic accept, tick, gap_last, last_bit;

  // ready_q is only high in IDLE, so this is the acceptance edge.
  assign accept   = bus.req_valid && ready_q;
  assign gap_last = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));
  assign last_bit = (bit_cnt_q == '0);

  spi_phase_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, and the output values that go with it (registered below).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)   state_d = ST_SETUP;
      ST_SETUP: if (tick)     state_d = ST_HIGH;
      ST_HIGH:  if (tick)     state_d = last_bit ? ST_HOLD : ST_LOW;
      ST_LOW:   if (tick)     state_d = ST_HIGH;
      ST_HOLD:  if (tick)     state_d = ST_GAP;
      ST_GAP:   if (gap_last) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
    sclk_d  = (state_d == ST_HIGH);
    ncs_d   = (state_d == ST_IDLE) || (state_d == ST_GAP);
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_HOLD) && (state_d == ST_GAP);
  end

  // Output registers, so every pin changes only on a clk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Shift register: load on acceptance, advance on entry to each LOW phase
  // so COPI changes one full half period before the next SCLK rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
    end else if (accept) begin
      shift_q <= {WRITE_FLAG, bus.req_addr, bus.req_data};
    end else if ((state_q == ST_HIGH) && (state_d == ST_LOW)) begin
      shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Bit counter: index of the bit currently on COPI, 15 down to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
    end else if (accept) begin
      bit_cnt_q <= BIT_CNT_W'(FRAME_BITS - 1);
    end else if ((state_q == ST_HIGH) && (state_d == ST_LOW)) begin
      bit_cnt_q <= bit_cnt_q - 1'b1;
    end
  end

  // Inter-frame gap counter, running only while in GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_q <= '0;
    end else if (state_q == ST_GAP) begin
      gap_cnt_q <= gap_cnt_q + 1'b1;
    end else begin
      gap_cnt_q <= '0;
    end
  end

  assign bus.SCLK      = sclk_q;
  assign bus.COPI      = shift_q[FRAME_BITS-1];
  assign bus.nCS       = ncs_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.req_ready = ready_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Bench for spi_reg_writer: two instances (CLK_DIV=4/GAP=4 and CLK_DIV=2/GAP=1)
// driven with directed and random writes; a pin-level monitor decodes frames
// and the results are compared to values computed from the frame rules.
module tb_spi_reg_writer;
  import spi_reg_pkg::*;

  localparam int DIV_A = 4;
  localparam int GAP_A = 4;
  localparam int DIV_B = 2;
  localparam int GAP_B = 1;
  localparam int LIMIT = 3000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic [1:0] rst_v;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req_valid_v;
  logic [6:0] req_addr_v [2];
  logic [7:0] req_data_v [2];
  logic [1:0] ready_w, sclk_w, copi_w, ncs_w, busy_w, done_w;
  state_t     state_w [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? DIV_A : DIV_B;
    localparam int G = (g == 0) ? GAP_A : GAP_B;
    spi_reg_writer_if bus ();
    assign bus.req_valid = req_valid_v[g];
    assign bus.req_addr  = req_addr_v[g];
    assign bus.req_data  = req_data_v[g];
    assign ready_w[g]    = bus.req_ready;
    assign sclk_w[g]     = bus.SCLK;
    assign copi_w[g]     = bus.COPI;
    assign ncs_w[g]      = bus.nCS;
    assign busy_w[g]     = bus.busy;
    assign done_w[g]     = bus.done;
    assign state_w[g]    = bus.state;
    spi_reg_writer #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
      .clk (clk),
      .rst (rst_v[g]),
      .bus (bus)
    );
  end

  function automatic int div_of(input int g);
    return (g == 0) ? DIV_A : DIV_B;
  endfunction

  function automatic int gap_of(input int g);
    return (g == 0) ? GAP_A : GAP_B;
  endfunction

  // ---------------- scoreboard ----------------
  int errors, checks;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- pin monitor ----------------
  bit mon_en;
  logic ncs_p [2], sclk_p [2], copi_p [2], ready_p [2];
  logic [15:0] shreg [2], last_bits [2];
  int rises [2], last_rises [2], low_len [2], last_low [2];
  int run_len [2], fr_bad [2], last_fr_bad [2];
  int high_len [2], last_gap [2], cyc [2], fall_cyc [2], last_period [2];
  int last_ready_lat [2], frames [2], dones [2];
  int frames_seen [2], dones_seen [2];
  int edge_bad, done_bad;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < 2; g++) begin
        if (!ncs_w[g]) begin
          if (ncs_p[g]) begin
            last_gap[g]    = high_len[g];
            last_period[g] = cyc[g] - fall_cyc[g];
            fall_cyc[g]    = cyc[g];
            low_len[g] = 1; rises[g] = 0; shreg[g] = '0; run_len[g] = 1; fr_bad[g] = 0;
            if (sclk_w[g]) fr_bad[g]++;
          end else begin
            low_len[g]++;
            if (sclk_w[g] != sclk_p[g]) begin
              if (run_len[g] != div_of(g)) fr_bad[g]++;
              run_len[g] = 1;
              if (sclk_w[g]) begin
                rises[g]++;
                shreg[g] = {shreg[g][14:0], copi_w[g]};
                if (copi_w[g] != copi_p[g]) fr_bad[g]++;
              end
            end else begin
              run_len[g]++;
              if (copi_w[g] != copi_p[g]) fr_bad[g]++;
            end
          end
        end else begin
          if (!ncs_p[g]) begin
            if (run_len[g] != div_of(g)) fr_bad[g]++;
            last_bits[g]   = shreg[g];
            last_rises[g]  = rises[g];
            last_low[g]    = low_len[g];
            last_fr_bad[g] = fr_bad[g];
            frames[g]++;
            high_len[g] = 1;
          end else begin
            high_len[g]++;
          end
          if (sclk_w[g]) edge_bad++;
        end
        if (ready_w[g] && !ready_p[g]) last_ready_lat[g] = high_len[g] - 1;
        if (done_w[g]) begin
          dones[g]++;
          if (!(ncs_w[g] && !ncs_p[g])) done_bad++;
        end
        ncs_p[g] = ncs_w[g]; sclk_p[g] = sclk_w[g];
        copi_p[g] = copi_w[g]; ready_p[g] = ready_w[g];
        cyc[g]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int g, input logic [6:0] a, input logic [7:0] d, input bit hold);
    int n;
    req_addr_v[g] = a;
    req_data_v[g] = d;
    req_valid_v[g] = 1'b1;
    n = 0;
    while (!ready_w[g] && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept_wait%0d", g), n < LIMIT, 1'b1);
    exp_q.push_back({1'b1, a, d});
    @(posedge clk);
    #1;
    if (!hold) req_valid_v[g] = 1'b0;
    check($sformatf("accept_pins%0d", g), {ncs_w[g], copi_w[g], busy_w[g], ready_w[g]}, 4'b0110);
  endtask

  task automatic verify_frame(input int g);
    int n;
    logic [15:0] e;
    n = 0;
    while (frames[g] <= frames_seen[g] && n < LIMIT) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("frame_seen%0d", g), n < LIMIT, 1'b1);
    frames_seen[g]++;
    check($sformatf("exp_avail%0d", g), exp_q.size() > 0, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check($sformatf("frame_bits%0d", g), last_bits[g], e);
    check($sformatf("rises%0d", g), last_rises[g], 16);
    check($sformatf("ncs_low%0d", g), last_low[g], 33 * div_of(g));
    check($sformatf("phase_copi%0d", g), last_fr_bad[g], 0);
    check($sformatf("done_cnt%0d", g), dones[g], dones_seen[g] + 1);
    dones_seen[g] = dones[g];
    check("done_pos", done_bad, 0);
    check("sclk_idle", edge_bad, 0);
  endtask

  task automatic wait_ready(input int g);
    int n;
    n = 0;
    while (!ready_w[g] && n < LIMIT) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("ready_wait%0d", g), n < LIMIT, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] a0;
    logic [7:0] d0;
    int bad;
    int n;
    errors = 0; checks = 0; mon_en = 1'b0;
    edge_bad = 0; done_bad = 0;
    rst_v = 2'b11;
    req_valid_v = 2'b00;
    for (int g = 0; g < 2; g++) begin
      req_addr_v[g] = '0; req_data_v[g] = '0;
    end
    repeat (5) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_ncs%0d", g), ncs_w[g], 1'b1);
      check($sformatf("rst_sclk%0d", g), sclk_w[g], 1'b0);
      check($sformatf("rst_copi%0d", g), copi_w[g], 1'b0);
      check($sformatf("rst_busy_done%0d", g), {busy_w[g], done_w[g]}, 2'b00);
      check($sformatf("rst_ready%0d", g), ready_w[g], 1'b1);
      check($sformatf("rst_state%0d", g), state_w[g], ST_IDLE);
      ncs_p[g] = 1'b1; sclk_p[g] = 1'b0; copi_p[g] = 1'b0; ready_p[g] = 1'b1;
    end
    rst_v = 2'b00;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single write: en_out_7_0 = 0xFF.
    send(0, ADDR_EN_OUT_7_0, 8'hFF, 1'b0);
    verify_frame(0);
    check("frame_80ff", last_bits[0], 16'h80FF);

    // Back-to-back writes with req_valid held.
    send(0, ADDR_PWM_DUTY, 8'h80, 1'b1);
    send(0, ADDR_EN_PWM_7_0, 8'h01, 1'b0);
    verify_frame(0);
    verify_frame(0);
    check("b2b_gap0", last_gap[0], GAP_A + 1);
    check("b2b_period0", last_period[0], 33 * DIV_A + GAP_A + 1);

    // Random writes on the default configuration.
    for (int i = 0; i < 4; i++) begin
      send(0, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b0);
      verify_frame(0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Fast configuration: 0x7F/0xA5 then a random back-to-back write.
    send(1, 7'h7F, 8'hA5, 1'b1);
    send(1, (($urandom_range(0, 1) == 0) ? ADDR_EN_OUT_15_8 : ADDR_EN_PWM_15_8),
         8'($urandom_range(0, 255)), 1'b0);
    verify_frame(1);
    check("frame_ffa5", last_bits[1], 16'hFFA5);
    verify_frame(1);
    check("b2b_gap1", last_gap[1], GAP_B + 1);
    check("period1", last_period[1], 68);
    wait_ready(1);
    check("ready_lat1", last_ready_lat[1], GAP_B);
    for (int i = 0; i < 3; i++) begin
      send(1, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b0);
      verify_frame(1);
    end

    // Requests presented while busy are neither accepted nor sampled.
    a0 = 7'($urandom_range(0, 127));
    d0 = 8'($urandom_range(0, 255));
    send(0, a0, d0, 1'b1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      req_addr_v[0] = 7'($urandom_range(0, 127));
      req_data_v[0] = 8'($urandom_range(0, 255));
      #1;
      if (ready_w[0] || !busy_w[0]) bad++;
    end
    req_valid_v[0] = 1'b0;
    verify_frame(0);
    check("busy_no_accept", bad, 0);
    wait_ready(0);
    check("ready_lat0", last_ready_lat[0], GAP_A);

    // Reset during the HIGH phase of bit 9 (the 7th bit sent).
    send(0, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)), 1'b0);
    n = 0;
    while (!(rises[0] == 7 && sclk_w[0]) && n < LIMIT) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bit9_reached", n < LIMIT, 1'b1);
    rst_v[0] = 1'b1;
    @(posedge clk);
    #1;
    check("abort_pins", {ncs_w[0], sclk_w[0], copi_w[0], ready_w[0], busy_w[0], done_w[0]},
          6'b100100);
    rst_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_done", dones[0], dones_seen[0]);
    frames_seen[0] = frames[0];
    exp_q.delete();
    send(0, ADDR_EN_OUT_15_8, 8'($urandom_range(0, 255)), 1'b0);
    verify_frame(0);

    // Requests while reset is held are ignored.
    n = frames[0];
    bad = 0;
    rst_v[0] = 1'b1;
    req_valid_v[0] = 1'b1;
    req_addr_v[0] = ADDR_PWM_DUTY;
    req_data_v[0] = 8'h55;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (!ncs_w[0] || sclk_w[0]) bad++;
    end
    req_valid_v[0] = 1'b0;
    @(negedge clk);
    rst_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("rst_hold_pins", bad, 0);
    check("rst_hold_frames", frames[0], n);
    check("rst_hold_ready", ready_w[0], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
